// File: rtl/debug_cmd_pkg.sv
// Shared constants and state encodings for the debug UART command receiver.
// DEBUG_CMD_CHECKSUM_EN selects the 4-byte frame with a trailing checksum byte.
package debug_cmd_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam logic [7:0] CMD_HALT  = 8'h01;
   localparam logic [7:0] CMD_STEP  = 8'h02;
   localparam logic [7:0] CMD_RESET = 8'h03;
   localparam logic [7:0] CMD_DUMP  = 8'h04;

   typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_state_t;

`ifdef DEBUG_CMD_CHECKSUM_EN
   typedef enum logic [1:0] {P_SYNC, P_CMD, P_ARG, P_CHK} parse_state_t;
`else
   typedef enum logic [1:0] {P_SYNC, P_CMD, P_ARG} parse_state_t;
`endif

   function automatic logic cmd_known(input logic [7:0] c);
      return (c >= CMD_HALT) && (c <= CMD_DUMP);
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer, falling-edge start detect, mid-bit sampling.
module uart_rx_byte
   import debug_cmd_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 104
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       stop_err
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic rx_meta, rx_sync, rx_prev;
   logic fall;

   byte_state_t   state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    bit_idx, bit_n;
   logic [7:0]    shreg, sh_n;
   logic          valid_n, err_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   assign fall = rx_prev & ~rx_sync;

   always_comb begin
      state_n = state;
      cnt_n   = cnt + 1'b1;
      bit_n   = bit_idx;
      sh_n    = shreg;
      valid_n = 1'b0;
      err_n   = 1'b0;
      case (state)
         B_IDLE: begin
            cnt_n = '0;
            if (fall) state_n = B_START;
         end
         B_START: begin
            // a start bit that is high again at mid-bit was a glitch
            if (cnt == HALF) begin
               cnt_n   = '0;
               bit_n   = '0;
               state_n = rx_sync ? B_IDLE : B_DATA;
            end
         end
         B_DATA: begin
            if (cnt == LAST) begin
               cnt_n = '0;
               sh_n  = {rx_sync, shreg[7:1]};
               bit_n = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_n = B_STOP;
            end
         end
         B_STOP: begin
            if (cnt == LAST) begin
               cnt_n   = '0;
               state_n = B_IDLE;
               if (rx_sync) valid_n = 1'b1;
               else         err_n   = 1'b1;
            end
         end
         default: state_n = B_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= B_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         byte_valid <= 1'b0;
         stop_err   <= 1'b0;
         byte_data  <= '0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         bit_idx    <= bit_n;
         shreg      <= sh_n;
         byte_valid <= valid_n;
         stop_err   <= err_n;
         if (valid_n) byte_data <= shreg;
      end
   end

endmodule

// File: rtl/debug_cmd_rx.sv
// Debug UART command receiver: frame parser, inter-byte timeout and command pulses.
// DEBUG_CMD_CHECKSUM_EN adds the CHK byte and its verification.
module debug_cmd_rx
   import debug_cmd_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 104,
   parameter int unsigned TIMEOUT_BITS = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       halt_toggle,
   output logic       step_req,
   output logic [7:0] step_count,
   output logic       core_rst_req,
   output logic       dump_req,
   output logic       frame_err
);

   localparam int unsigned LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int unsigned TW    = $clog2(LIMIT);

   logic          stop_err;
   logic [TW-1:0] tmr;
   logic          timeout;

   parse_state_t pstate, pstate_n;
   logic [7:0]   cmd_q, cmd_n, sc_n, dec_arg;
   logic         dec_en, dec_ok;
   logic         halt_n, step_n, crst_n, dump_n, err_n;
`ifdef DEBUG_CMD_CHECKSUM_EN
   logic [7:0]   arg_q, arg_n;
`endif

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .stop_err   (stop_err)
   );

   // counts cycles since the last accepted byte while a frame is open
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                               tmr <= '0;
      else if (pstate == P_SYNC || byte_valid) tmr <= '0;
      else                                   tmr <= tmr + 1'b1;
   end

   assign timeout = (pstate != P_SYNC) && !byte_valid && (tmr == TW'(LIMIT - 1));

   always_comb begin
      pstate_n = pstate;
      cmd_n    = cmd_q;
      sc_n     = step_count;
      halt_n   = 1'b0;
      step_n   = 1'b0;
      crst_n   = 1'b0;
      dump_n   = 1'b0;
      err_n    = 1'b0;
      dec_en   = 1'b0;
      dec_ok   = 1'b0;
      dec_arg  = byte_data;
`ifdef DEBUG_CMD_CHECKSUM_EN
      arg_n    = arg_q;
`endif
      if (stop_err || timeout) begin
         err_n    = 1'b1;
         pstate_n = P_SYNC;
      end else if (byte_valid) begin
         case (pstate)
            P_SYNC: if (byte_data == SYNC_BYTE) pstate_n = P_CMD;
            P_CMD: begin
               cmd_n    = byte_data;
               pstate_n = P_ARG;
            end
`ifdef DEBUG_CMD_CHECKSUM_EN
            P_ARG: begin
               arg_n    = byte_data;
               pstate_n = P_CHK;
            end
            P_CHK: begin
               dec_en   = 1'b1;
               dec_arg  = arg_q;
               dec_ok   = (byte_data == (cmd_q ^ arg_q ^ SYNC_BYTE));
               pstate_n = P_SYNC;
            end
`else
            P_ARG: begin
               dec_en   = 1'b1;
               dec_ok   = 1'b1;
               pstate_n = P_SYNC;
            end
`endif
            default: pstate_n = P_SYNC;
         endcase
      end
      if (dec_en) begin
         if (dec_ok && cmd_known(cmd_q)) begin
            case (cmd_q)
               CMD_HALT:  halt_n = 1'b1;
               CMD_STEP: begin
                  step_n = 1'b1;
                  sc_n   = dec_arg;
               end
               CMD_RESET: crst_n = 1'b1;
               CMD_DUMP:  dump_n = 1'b1;
               default:   err_n  = 1'b1;
            endcase
         end else begin
            err_n = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pstate       <= P_SYNC;
         cmd_q        <= '0;
         step_count   <= '0;
         halt_toggle  <= 1'b0;
         step_req     <= 1'b0;
         core_rst_req <= 1'b0;
         dump_req     <= 1'b0;
         frame_err    <= 1'b0;
`ifdef DEBUG_CMD_CHECKSUM_EN
         arg_q        <= '0;
`endif
      end else begin
         pstate       <= pstate_n;
         cmd_q        <= cmd_n;
         step_count   <= sc_n;
         halt_toggle  <= halt_n;
         step_req     <= step_n;
         core_rst_req <= crst_n;
         dump_req     <= dump_n;
         frame_err    <= err_n;
`ifdef DEBUG_CMD_CHECKSUM_EN
         arg_q        <= arg_n;
`endif
      end
   end

endmodule
